// File: rtl/oled_pkg.sv
// Shared keypad/OLED definitions: key code map, entry FSM states and a digit decode helper.
// KEYPAD_ECHO_EN adds the ECHO state to the FSM encoding.
package oled_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'hC;
    localparam logic [3:0] KEY_CLEAR     = 4'hD;
    localparam logic [3:0] KEY_BKSP      = 4'hE;
    localparam logic [3:0] KEY_ENTER     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ISSUE = 2'd2
`ifdef KEYPAD_ECHO_EN
        , ST_ECHO = 2'd3
`endif
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= KEY_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Key event input and completed-entry command port of the keypad entry controller.
interface keypad_entry_ctrl_if #(
    parameter int DIGITS = 4
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic [3:0]          key_code;
    logic                key_valid;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [4*DIGITS-1:0] cmd_data;
    logic [CNT_W-1:0]    cmd_len;

    modport master (
        output key_code, key_valid, cmd_ready,
        input  cmd_valid, cmd_data, cmd_len
    );

    modport slave (
        input  key_code, key_valid, cmd_ready,
        output cmd_valid, cmd_data, cmd_len
    );

endinterface

// File: rtl/keypad_evt_fifo.sv
// Synchronous key-event FIFO with full/empty flags; a push while full is accepted only
// when a pop happens in the same cycle.
module keypad_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_s, pop_s;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        pop_s    = pop & ~empty;
        push_s   = push & (~full | pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: queues key events and edits a hex entry buffer, issuing the
// entry on ENTER. Optional echo port enabled with KEYPAD_ECHO_EN.
module keypad_entry_ctrl
    import oled_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    keypad_entry_ctrl_if.slave           bus,
    output logic [$clog2(DIGITS+1)-1:0]  entry_count,
    output logic                         key_drop,
    output logic                         digit_ovf,
    output logic                         busy
`ifdef KEYPAD_ECHO_EN
    ,
    output logic                         echo_valid,
    input  logic                         echo_ready,
    output logic [3:0]                   echo_char,
    output logic                         echo_del
`endif
);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int BUF_W = 4 * DIGITS;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         code_q, code_d;
    logic               key_drop_q, key_drop_d;
    logic               digit_ovf_q, digit_ovf_d;
    logic               pop_s;
    logic               fifo_full_s, fifo_empty_s;
    logic [3:0]         fifo_rd_s;
`ifdef KEYPAD_ECHO_EN
    logic [3:0]         echo_char_q, echo_char_d;
    logic               echo_del_q, echo_del_d;
`endif

    keypad_evt_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.key_valid),
        .wr_data (bus.key_code),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign bus.cmd_valid = (state_q == ST_ISSUE);
    assign bus.cmd_data  = buf_q;
    assign bus.cmd_len   = cnt_q;
    assign entry_count   = cnt_q;
    assign key_drop      = key_drop_q;
    assign digit_ovf     = digit_ovf_q;
    assign busy          = (state_q != ST_IDLE) | ~fifo_empty_s;
`ifdef KEYPAD_ECHO_EN
    assign echo_valid    = (state_q == ST_ECHO);
    assign echo_char     = echo_char_q;
    assign echo_del      = echo_del_q;
`endif

    // Entry FSM next-state and buffer edit decode.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        pop_s       = 1'b0;
        digit_ovf_d = 1'b0;
`ifdef KEYPAD_ECHO_EN
        echo_char_d = echo_char_q;
        echo_del_d  = echo_del_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    code_d  = fifo_rd_s;
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                if (is_digit(code_q)) begin
                    if (cnt_q < CNT_W'(DIGITS)) begin
                        buf_d = {buf_q[BUF_W-5:0], code_q};
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef KEYPAD_ECHO_EN
                        echo_char_d = code_q;
                        echo_del_d  = 1'b0;
                        state_d     = ST_ECHO;
`endif
                    end else begin
                        digit_ovf_d = 1'b1;
                    end
                end else begin
                    case (code_q)
                        KEY_CLEAR: begin
                            buf_d = '0;
                            cnt_d = '0;
                        end
                        KEY_BKSP: begin
                            if (cnt_q != '0) begin
                                buf_d = {4'h0, buf_q[BUF_W-1:4]};
                                cnt_d = cnt_q - CNT_W'(1);
`ifdef KEYPAD_ECHO_EN
                                echo_char_d = 4'h0;
                                echo_del_d  = 1'b1;
                                state_d     = ST_ECHO;
`endif
                            end else begin
                                cnt_d = cnt_q;
                            end
                        end
                        KEY_ENTER: begin
                            if (cnt_q != '0) begin
                                state_d = ST_ISSUE;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
`ifdef KEYPAD_ECHO_EN
            ST_ECHO: begin
                if (echo_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ECHO;
                end
            end
`endif
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A press is lost only when the queue is full and nothing leaves it this cycle.
    always_comb begin
        key_drop_d = bus.key_valid & fifo_full_s & ~pop_s;
    end

    // FSM state, entry buffer and status pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            code_q      <= 4'h0;
            key_drop_q  <= 1'b0;
            digit_ovf_q <= 1'b0;
`ifdef KEYPAD_ECHO_EN
            echo_char_q <= 4'h0;
            echo_del_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            key_drop_q  <= key_drop_d;
            digit_ovf_q <= digit_ovf_d;
`ifdef KEYPAD_ECHO_EN
            echo_char_q <= echo_char_d;
            echo_del_q  <= echo_del_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: expected commands are queued at ENTER and
// checked by a monitor on each handshake. Echo checks build with KEYPAD_ECHO_EN.
module tb_keypad_entry_ctrl;
    import oled_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_ctrl_if #(.DIGITS(4)) kif ();

    logic [2:0] entry_count;
    logic       key_drop;
    logic       digit_ovf;
    logic       busy;
`ifdef KEYPAD_ECHO_EN
    logic       echo_valid;
    logic       echo_ready = 1'b1;
    logic [3:0] echo_char;
    logic       echo_del;
`endif

    keypad_entry_ctrl #(.DIGITS(4), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (kif),
        .entry_count (entry_count),
        .key_drop    (key_drop),
        .digit_ovf   (digit_ovf),
        .busy        (busy)
`ifdef KEYPAD_ECHO_EN
        ,
        .echo_valid  (echo_valid),
        .echo_ready  (echo_ready),
        .echo_char   (echo_char),
        .echo_del    (echo_del)
`endif
    );

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  len;
    } cmd_t;

    cmd_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_hs   = 0;
    int   n_drop = 0;
    int   n_ovf  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: count status pulses, score each command handshake against the queue.
    always @(negedge clk) begin
        if (rst) begin
            if (key_drop)  n_drop++;
            if (digit_ovf) n_ovf++;
            if (kif.cmd_valid && kif.cmd_ready) begin
                cmd_t e;
                n_hs++;
                chk("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("cmd_data", 32'(kif.cmd_data), 32'(e.data));
                    chk("cmd_len",  32'(kif.cmd_len),  32'(e.len));
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] code);
        kif.key_code  = code;
        kif.key_valid = 1'b1;
        step();
        kif.key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
        step(2);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!kif.cmd_valid && k < 50) begin
            step();
            k++;
        end
        chk({name, "_valid"}, 32'(kif.cmd_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        kif.key_code  = 4'h0;
        kif.key_valid = 1'b0;
        kif.cmd_ready = 1'b0;
        step(3);
        chk("rst_cmd_valid", 32'(kif.cmd_valid), 32'd0);
        chk("rst_cmd_data",  32'(kif.cmd_data),  32'd0);
        chk("rst_cmd_len",   32'(kif.cmd_len),   32'd0);
        chk("rst_entry",     32'(entry_count),   32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_pulses",    32'({key_drop, digit_ovf}), 32'd0);
        rst = 1'b1;
        step(2);

        // 1,2,3,ENTER with exact press-to-count latency on the first digit.
        kif.cmd_ready = 1'b1;
        press(4'h1);
        step();
        chk("lat_t2_entry", 32'(entry_count), 32'd0);
        step();
        chk("lat_t3_entry", 32'(entry_count), 32'd1);
        wait_idle("t1_d1");
        press(4'h2); wait_idle("t1_d2");
        press(4'h3); wait_idle("t1_d3");
        chk("t1_entry", 32'(entry_count), 32'd3);
        exp_q.push_back('{data: 16'h0123, len: 3'd3});
        press(KEY_ENTER); wait_idle("t1_enter");
        chk("t1_entry_after", 32'(entry_count), 32'd0);
        chk("t1_hs", 32'(n_hs), 32'd1);

        // Five digits into a four-digit buffer.
        for (int i = 1; i <= 5; i++) begin
            press(4'(i));
            wait_idle("t2_digit");
        end
        chk("t2_ovf", 32'(n_ovf), 32'd1);
        chk("t2_entry", 32'(entry_count), 32'd4);
        exp_q.push_back('{data: 16'h1234, len: 3'd4});
        press(KEY_ENTER); wait_idle("t2_enter");
        chk("t2_hs", 32'(n_hs), 32'd2);

        // A,B,BACKSPACE,C then empty-buffer BACKSPACE/ENTER.
        press(4'hA); wait_idle("t3_a");
        press(4'hB); wait_idle("t3_b");
        press(KEY_BKSP); wait_idle("t3_bs");
        press(4'hC); wait_idle("t3_c");
        chk("t3_entry", 32'(entry_count), 32'd2);
        exp_q.push_back('{data: 16'h00AC, len: 3'd2});
        press(KEY_ENTER); wait_idle("t3_enter");
        chk("t3_hs", 32'(n_hs), 32'd3);
        press(KEY_BKSP); wait_idle("t3_bs0");
        press(KEY_ENTER); wait_idle("t3_ent0");
        chk("t3_no_cmd", 32'(n_hs), 32'd3);
        chk("t3_entry0", 32'(entry_count), 32'd0);

        // Back-pressure in ISSUE: four queue, fifth dropped, then drained in order.
        kif.cmd_ready = 1'b0;
        press(4'h7);
        press(KEY_ENTER);
        wait_valid("t4");
        exp_q.push_back('{data: 16'h0007, len: 3'd1});
        press(4'h3);
        press(4'h4);
        press(KEY_ENTER);
        press(4'h5);
        press(4'h6);
        step(2);
        chk("t4_drop", 32'(n_drop), 32'd1);
        chk("t4_hold_valid", 32'(kif.cmd_valid), 32'd1);
        chk("t4_hold_data", 32'(kif.cmd_data), 32'h0007);
        chk("t4_hold_len", 32'(kif.cmd_len), 32'd1);
        exp_q.push_back('{data: 16'h0034, len: 3'd2});
        kif.cmd_ready = 1'b1;
        wait_idle("t4_drain");
        chk("t4_hs", 32'(n_hs), 32'd5);
        chk("t4_entry", 32'(entry_count), 32'd1);
        press(KEY_CLEAR); wait_idle("t4_clear");
        chk("t4_cleared", 32'(entry_count), 32'd0);

        // Reset while a command is pending and events are queued.
        kif.cmd_ready = 1'b0;
        press(4'h9);
        press(KEY_ENTER);
        wait_valid("t5");
        press(4'h2);
        press(4'h3);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_valid_drop", 32'(kif.cmd_valid), 32'd0);
        chk("t5_entry", 32'(entry_count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        step(2);
        rst = 1'b1;
        step(4);
        chk("t5_busy_after", 32'(busy), 32'd0);
        chk("t5_entry_after", 32'(entry_count), 32'd0);
        chk("t5_hs", 32'(n_hs), 32'd5);

`ifdef KEYPAD_ECHO_EN
        // Echo held under back-pressure, then a backspace echo.
        kif.cmd_ready = 1'b1;
        echo_ready = 1'b0;
        press(4'h7);
        step(10);
        chk("t6_echo_valid", 32'(echo_valid), 32'd1);
        chk("t6_echo_char", 32'(echo_char), 32'h7);
        chk("t6_echo_del", 32'(echo_del), 32'd0);
        chk("t6_entry", 32'(entry_count), 32'd1);
        echo_ready = 1'b1;
        wait_idle("t6_digit");
        echo_ready = 1'b0;
        press(KEY_BKSP);
        step(5);
        chk("t6_bs_valid", 32'(echo_valid), 32'd1);
        chk("t6_bs_del", 32'(echo_del), 32'd1);
        chk("t6_bs_char", 32'(echo_char), 32'h0);
        chk("t6_bs_entry", 32'(entry_count), 32'd0);
        echo_ready = 1'b1;
        wait_idle("t6_bs");
`endif

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
